// File: rtl/emu_mem_arbiter_pkg.sv
// Shared definitions for the emulator memory arbiter: memory geometry, streak limit,
// register indices, supervisor-call codes and the pending-response records.
package emu_mem_arbiter_pkg;

    localparam int unsigned ARB_MEM_DEPTH  = 1024;
    localparam int unsigned ARB_MEM_AW     = 10;
    localparam int unsigned ARB_MAX_STREAK = 4;

    localparam int unsigned REG_SP = 13;
    localparam int unsigned REG_LR = 14;
    localparam int unsigned REG_PC = 15;

    typedef enum logic [7:0] {
        SVC_EXIT  = 8'h00,
        SVC_PUTC  = 8'h01,
        SVC_GETC  = 8'h02,
        SVC_TICKS = 8'h03
    } svc_code_e;

    typedef struct packed {
        logic valid;
        logic err;
        logic hi_half;
    } if_rsp_t;

    typedef struct packed {
        logic valid;
        logic err;
        logic is_store;
    } d_rsp_t;

    function automatic logic word_in_range(input logic [31:0] word_addr,
                                           input int unsigned depth);
        return word_addr < 32'(depth);
    endfunction

endpackage

// File: rtl/emu_arb_prio.sv
// Combinational grant select between fetch and data requesters.
// Data wins ties unless the data streak is full, then the waiting fetch goes first.
module emu_arb_prio (
    input  logic if_req,
    input  logic d_req,
    input  logic streak_full,
    output logic if_gnt,
    output logic d_gnt
);

    always_comb begin
        if_gnt = if_req & (~d_req | streak_full);
        d_gnt  = d_req & ~(if_req & streak_full);
    end

endmodule

// File: rtl/emu_mem_arbiter.sv
// Shares the single-port word RAM between halfword fetch and word load/store traffic.
// One grant per cycle, response one cycle later, fetch protected from data starvation.
module emu_mem_arbiter
    import emu_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = ARB_MEM_DEPTH,
    parameter int unsigned MEM_AW     = ARB_MEM_AW,
    parameter int unsigned MAX_STREAK = ARB_MAX_STREAK
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_pc,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [15:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    if_rsp_t             if_rsp_q, if_rsp_d;
    d_rsp_t              d_rsp_q, d_rsp_d;

    logic streak_full;
    logic if_gnt_w, d_gnt_w;
    logic if_oor, d_oor;
    logic unused_pc0;

    assign unused_pc0  = if_pc[0];
    assign streak_full = (streak_q == STREAK_W'(MAX_STREAK));
    assign if_oor      = ~word_in_range({2'b00, if_pc[31:2]}, MEM_DEPTH);
    assign d_oor       = ~word_in_range(d_addr, MEM_DEPTH);

    // Requests are masked during reset so no grant can leak out of it.
    emu_arb_prio u_prio (
        .if_req      (if_req & ~reset),
        .d_req       (d_req & ~reset),
        .streak_full (streak_full),
        .if_gnt      (if_gnt_w),
        .d_gnt       (d_gnt_w)
    );

    always_comb begin
        streak_d    = streak_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;

        if (if_gnt_w || !if_req) begin
            streak_d = '0;
        end else if (d_gnt_w && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        // Out-of-range requests are still granted but never reach the RAM.
        if (if_gnt_w) begin
            mem_addr_d = if_pc[MEM_AW+1:2];
            mem_en     = ~if_oor;
        end else if (d_gnt_w) begin
            mem_addr_d  = d_addr[MEM_AW-1:0];
            mem_wdata_d = d_wdata;
            mem_en      = ~d_oor;
            mem_we      = d_we & ~d_oor;
        end

        if_rsp_d.valid    = if_gnt_w;
        if_rsp_d.err      = if_oor;
        if_rsp_d.hi_half  = if_pc[1];
        d_rsp_d.valid     = d_gnt_w;
        d_rsp_d.err       = d_oor;
        d_rsp_d.is_store  = d_we;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rsp_q    <= '0;
            d_rsp_q     <= '0;
        end else begin
            streak_q    <= streak_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rsp_q    <= if_rsp_d;
            d_rsp_q     <= d_rsp_d;
        end
    end

    // Responses are gated by reset so a grant just before reset is dropped.
    always_comb begin
        if_gnt    = if_gnt_w;
        d_gnt     = d_gnt_w;
        mem_addr  = reset ? '0 : mem_addr_d;
        mem_wdata = reset ? '0 : mem_wdata_d;

        if_rvalid = if_rsp_q.valid & ~if_flush & ~reset;
        if_err    = if_rvalid & if_rsp_q.err;
        if_rdata  = '0;
        if (if_rvalid && !if_rsp_q.err) begin
            if_rdata = if_rsp_q.hi_half ? mem_rdata[31:16] : mem_rdata[15:0];
        end

        d_rvalid = d_rsp_q.valid & ~reset;
        d_err    = d_rvalid & d_rsp_q.err;
        d_rdata  = '0;
        if (d_rvalid && !d_rsp_q.err && !d_rsp_q.is_store) begin
            d_rdata = mem_rdata;
        end
    end

endmodule
